tone_decoder: RTL and testbench
===============================

// Module: tone_decoder
// PURPOSE
//  Receive end of the buzzer tone path: measures the half-period of a square-wave input and
//  identifies which scale note (duo..duo1) is present. Lets the bench or a mic comparator check
//  generated tones in-system, and drives note display logic. Sits between a pin and status logic.
// PARAMETERS
//  PRESCALE  12  clk cycles per measurement tick (same 1/12 tick as the tone generator)
//  TOL       16  allowed |measured - expected| in ticks for a note match
//  CONFIRM   2   consecutive matching half-periods needed to lock (legal 1..3)
//  CNT_W     13  width of the half-period counter; saturates at 2**CNT_W-1
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active low
//  tone_in      in   1      asynchronous square wave to decode
//  note         out  3      locked note index: 0=duo 1=lai 2=mi 3=fa 4=suo 5=la 6=xi 7=duo1
//  note_valid   out  1      1 while a note is locked
//  note_strobe  out  1      one-cycle pulse on each entry to LOCKED
//  silence      out  1      1 when no edge has been seen for 2**CNT_W-1 ticks
//  half_period  out  CNT_W  last completed half-period measurement, in ticks
// BEHAVIOUR
//  Reset (rst=0, async): note=0, note_valid=0, note_strobe=0, silence=1, half_period=0,
//   prescaler=0, counter=0, state=SILENT, candidate=0, confirm count=0.
//  Input: 2-flop synchroniser, then edge detect on both edges. edge = 1-cycle pulse.
//  Tick: prescaler counts 0..PRESCALE-1 and pulses tick at PRESCALE-1.
//  Counter: +1 per tick, saturating at 2**CNT_W-1.
//   On edge: half_period<=counter, counter<=0. Edge wins over a simultaneous tick; that tick is dropped.
//  Expected ticks per half-period = divisor+1:
//   3823, 3406, 3035, 2866, 2552, 2274, 2025, 1912.
//  Classifier (combinational on counter at edge): match if |counter-expected| <= TOL.
//   Lowest index wins; no match -> miss.
//  FSM, evaluated only on edge unless noted:
//   SILENT: edge -> ACQUIRE. This measurement is discarded (partial). silence<=0.
//   ACQUIRE: miss -> confirm=0.
//    Hit on idx==candidate -> confirm+1. Hit on another idx -> candidate=idx, confirm=1.
//    When confirm reaches CONFIRM -> LOCKED: note<=candidate, note_valid<=1, note_strobe<=1.
//   LOCKED: hit on idx==note -> stay.
//    Hit on another idx -> ACQUIRE, note_valid<=0, candidate=idx, confirm=1.
//    Miss -> ACQUIRE, note_valid<=0, confirm=0.
//   Any state: counter saturated and no edge this cycle -> SILENT.
//    note_valid<=0, silence<=1, confirm=0. note holds its last value.
//  Latency: outputs update 1 clk after the edge pulse, i.e. 3-4 clk after the pin edge.
//  CONFIRM=1: lock on the first full matching half-period.
//  Saturation value never matches, since 8191 > 3823+TOL for TOL < 4368.
// STRUCTURE
//  Shared package: note divisor constants (duo..duo1, shared with the tone generator),
//   note index localparams, tick prescale constant.
//  Sub-module tone_period_meter: synchroniser, edge detect, prescaler, saturating counter.
//   Outputs edge, half-period value, saturated.
//  Top: classifier and FSM.
// TESTING
//  1. Hold rst=0 mid-stream -> all outputs at reset values immediately.
//     silence=1 and note_valid=0 after release.
//  2. Toggle tone_in every 3823*12 clk -> note_valid=1, note=0 after 3rd edge.
//     Exactly one note_strobe; half_period in 3822..3824.
//  3. Locked on duo, switch to 2274*12 clk -> note_valid=0 after first la edge.
//     Relock with note=5 after 2 la half-periods.
//  4. Half-period 3035+16 ticks -> locks note=2. Half-period 3035+17 ticks -> never valid, silence=0.
//  5. Stop toggling while locked -> silence=1, note_valid=0 at (8191 ticks)*12 +/-12 clk after last edge.
//  6. Short glitch pulse (<10 ticks) while locked on xi -> note_valid drops.
//     Relock on note=6 after 2 further clean half-periods.

Source files
------------

// File: rtl/tone_decoder_pkg.sv
// Shared tone constants: note divisors (common with the tone generator), note indices,
// tick prescale and the half-period classifier used by the decoder.
package tone_decoder_pkg;

  localparam int TICK_PRESCALE = 12;
  localparam int NOTE_TOL      = 16;
  localparam int CNT_W_DEF     = 13;
  localparam int NUM_NOTES     = 8;

  localparam logic [2:0] NOTE_DUO  = 3'd0;
  localparam logic [2:0] NOTE_LAI  = 3'd1;
  localparam logic [2:0] NOTE_MI   = 3'd2;
  localparam logic [2:0] NOTE_FA   = 3'd3;
  localparam logic [2:0] NOTE_SUO  = 3'd4;
  localparam logic [2:0] NOTE_LA   = 3'd5;
  localparam logic [2:0] NOTE_XI   = 3'd6;
  localparam logic [2:0] NOTE_DUO1 = 3'd7;

  localparam logic [12:0] DIV_DUO  = 13'd3822;
  localparam logic [12:0] DIV_LAI  = 13'd3405;
  localparam logic [12:0] DIV_MI   = 13'd3034;
  localparam logic [12:0] DIV_FA   = 13'd2865;
  localparam logic [12:0] DIV_SUO  = 13'd2551;
  localparam logic [12:0] DIV_LA   = 13'd2273;
  localparam logic [12:0] DIV_XI   = 13'd2024;
  localparam logic [12:0] DIV_DUO1 = 13'd1911;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } note_class_t;

  function automatic logic [12:0] note_divisor(input logic [2:0] idx);
    logic [12:0] div;
    case (idx)
      NOTE_DUO:  div = DIV_DUO;
      NOTE_LAI:  div = DIV_LAI;
      NOTE_MI:   div = DIV_MI;
      NOTE_FA:   div = DIV_FA;
      NOTE_SUO:  div = DIV_SUO;
      NOTE_LA:   div = DIV_LA;
      NOTE_XI:   div = DIV_XI;
      NOTE_DUO1: div = DIV_DUO1;
      default:   div = DIV_DUO;
    endcase
    return div;
  endfunction

  // A generator half-period lasts divisor+1 ticks; scanning downward lets the lowest index win.
  function automatic note_class_t classify(input logic [15:0] cnt, input logic [15:0] tol);
    note_class_t res;
    logic [16:0] expd;
    logic [16:0] meas;
    logic [16:0] diff;
    res  = '{hit: 1'b0, idx: 3'd0};
    meas = {1'b0, cnt};
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      expd = 17'(note_divisor(3'(i))) + 17'd1;
      if (meas >= expd) begin
        diff = meas - expd;
      end else begin
        diff = expd - meas;
      end
      if (diff <= {1'b0, tol}) begin
        res.hit = 1'b1;
        res.idx = 3'(i);
      end else begin
        res.hit = res.hit;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tone_decoder_period_meter.sv
// Measures input half-periods: synchroniser, both-edge detect, tick prescaler and a
// saturating tick counter captured into half_period on every edge.
module tone_period_meter
  import tone_decoder_pkg::*;
#(
  parameter int PRESCALE = TICK_PRESCALE,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] half_period,
  output logic             saturated
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic             sync1_q, sync2_q, prev_q;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             tick;

  assign edge_pulse  = sync2_q ^ prev_q;
  assign tick        = (ps_q == PS_MAX);
  assign saturated   = (cnt_q == {CNT_W{1'b1}});
  assign count       = cnt_q;
  assign half_period = hp_q;

  // An edge restarts the count and swallows any tick landing on the same cycle.
  always_comb begin
    ps_d = tick ? {PS_W{1'b0}} : ps_q + {{(PS_W-1){1'b0}}, 1'b1};
    hp_d = hp_q;
    if (edge_pulse) begin
      cnt_d = {CNT_W{1'b0}};
      hp_d  = cnt_q;
    end else if (tick && !saturated) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      ps_q    <= {PS_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      hp_q    <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder top: classifies each measured half-period against the note table and
// locks onto a note after CONFIRM consecutive matches of the same index.
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int PRESCALE = TICK_PRESCALE,
  parameter int TOL      = NOTE_TOL,
  parameter int CONFIRM  = 2,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             note_strobe,
  output logic             silence,
  output logic [CNT_W-1:0] half_period
);

  localparam logic [1:0] ST_SILENT  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] CONF_LOCK  = 2'(CONFIRM);

  logic             edge_s, sat_s;
  logic [CNT_W-1:0] cnt_s;
  note_class_t      cls_s;

  logic [1:0] state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [1:0] conf_q, conf_d;
  logic [2:0] note_q, note_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       silence_q, silence_d;
  logic [2:0] cand_sel;
  logic [1:0] conf_sel;

  tone_period_meter #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_meter (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .edge_pulse  (edge_s),
    .count       (cnt_s),
    .half_period (half_period),
    .saturated   (sat_s)
  );

  assign cls_s = classify(16'(cnt_s), 16'(TOL));

  // Next-state logic; only an edge or a silent counter moves the FSM.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    conf_d    = conf_q;
    note_d    = note_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    silence_d = silence_q;
    cand_sel  = cand_q;
    conf_sel  = conf_q;
    if (sat_s && !edge_s) begin
      state_d   = ST_SILENT;
      valid_d   = 1'b0;
      silence_d = 1'b1;
      conf_d    = 2'd0;
    end else if (edge_s) begin
      case (state_q)
        ST_SILENT: begin
          // The first measurement after silence is partial and is discarded.
          state_d   = ST_ACQUIRE;
          silence_d = 1'b0;
          conf_d    = 2'd0;
        end
        ST_ACQUIRE: begin
          if (!cls_s.hit) begin
            conf_d = 2'd0;
          end else begin
            if (cls_s.idx == cand_q) begin
              conf_sel = conf_q + 2'd1;
            end else begin
              cand_sel = cls_s.idx;
              conf_sel = 2'd1;
            end
            cand_d = cand_sel;
            if (conf_sel >= CONF_LOCK) begin
              state_d  = ST_LOCKED;
              note_d   = cand_sel;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
              conf_d   = 2'd0;
            end else begin
              conf_d = conf_sel;
            end
          end
        end
        ST_LOCKED: begin
          if (!cls_s.hit) begin
            state_d = ST_ACQUIRE;
            valid_d = 1'b0;
            conf_d  = 2'd0;
          end else if (cls_s.idx != note_q) begin
            state_d = ST_ACQUIRE;
            valid_d = 1'b0;
            cand_d  = cls_s.idx;
            conf_d  = 2'd1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_SILENT;
          valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SILENT;
      cand_q    <= 3'd0;
      conf_q    <= 2'd0;
      note_q    <= 3'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      silence_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      conf_q    <= conf_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      silence_q <= silence_d;
    end
  end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign silence     = silence_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder, run with a one-clock tick so each tick is one clk.
module tb_tone_decoder;

  localparam int P    = 1;
  localparam int SAT  = 8191;
  localparam int TOLB = 16;
  localparam int CHK  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tone_in = 1'b0;
  logic [2:0]  note;
  logic        note_valid, note_strobe, silence;
  logic [12:0] half_period;

  tone_decoder #(.PRESCALE(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .silence     (silence),
    .half_period (half_period)
  );

  always #5 clk = ~clk;

  int exp_ticks [8] = '{3823, 3406, 3035, 2866, 2552, 2274, 2025, 1912};
  int cyc = 0;
  int strobes = 0;
  int last_tgl = 0;
  int n_total = 0;
  int n_pass = 0;

  // Reference model state, advanced once per half-period.
  int m_silent, m_run, m_idx, m_note, m_valid, m_hp, m_strobes;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (note_strobe === 1'b1) strobes = strobes + 1;

  function automatic int ref_class(input int t);
    for (int i = 0; i < 8; i++) begin
      int d;
      d = t - exp_ticks[i];
      if (d < 0) d = -d;
      if (d <= TOLB) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_silent = 1; m_run = 0; m_idx = 0; m_note = 0; m_valid = 0; m_hp = 0;
    last_tgl = cyc;
  endtask

  // Toggle the pin n clocks after the previous toggle; update the model; optionally settle.
  task automatic drive_half(input int n, input bit settle);
    int gap, meas, c;
    while (cyc - last_tgl < n) @(negedge clk);
    tone_in = ~tone_in;
    gap = cyc - last_tgl;
    last_tgl = cyc;
    meas = (gap - 1 > SAT) ? SAT : gap - 1;
    m_hp = meas;
    if (m_silent != 0 || gap >= SAT + 2) begin
      m_silent = 0; m_run = 0; m_valid = 0;
    end else begin
      c = ref_class(meas);
      if (c < 0) m_run = 0;
      else if (m_run > 0 && c == m_idx) m_run++;
      else begin m_idx = c; m_run = 1; end
      m_valid = (m_run >= 2) ? 1 : 0;
      if (m_run == 2) begin m_note = m_idx; m_strobes++; end
    end
    if (settle) repeat (CHK) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (note !== 3'd0) $display("FAIL reset_note got %0d want 0", note); else n_pass++;
    n_total++; if (note_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", note_valid); else n_pass++;
    n_total++; if (silence !== 1'b1) $display("FAIL reset_silence got %b want 1", silence); else n_pass++;
    n_total++; if (half_period !== 13'd0) $display("FAIL reset_hp got %0d want 0", half_period); else n_pass++;
    rst = 1'b1;
    model_reset();
    repeat (CHK) @(negedge clk);
    n_total++; if (silence !== 1'b1 || note_valid !== 1'b0)
      $display("FAIL reset_release got silence=%b valid=%b want 1 0", silence, note_valid); else n_pass++;
  endtask

  task automatic test_duo();
    int s0;
    s0 = strobes;
    drive_half(100, 1'b1);
    n_total++; if (silence !== 1'b0 || note_valid !== 1'b0)
      $display("FAIL duo_first got silence=%b valid=%b want 0 0", silence, note_valid); else n_pass++;
    drive_half(3823, 1'b1);
    n_total++; if (note_valid !== 1'b0) $display("FAIL duo_second got valid=%b want 0", note_valid); else n_pass++;
    drive_half(3823, 1'b1);
    n_total++; if (note_valid !== 1'b1 || note !== 3'd0)
      $display("FAIL duo_lock got valid=%b note=%0d want 1 0", note_valid, note); else n_pass++;
    n_total++; if (int'(half_period) != m_hp || half_period < 13'd3822 || half_period > 13'd3824)
      $display("FAIL duo_hp got %0d want %0d", half_period, m_hp); else n_pass++;
    n_total++; if (strobes - s0 != 1) $display("FAIL duo_strobe got %0d want 1", strobes - s0); else n_pass++;
  endtask

  task automatic test_switch();
    drive_half(2274, 1'b1);
    n_total++; if (note_valid !== 1'b0) $display("FAIL la_drop got valid=%b want 0", note_valid); else n_pass++;
    drive_half(2274, 1'b1);
    n_total++; if (note_valid !== 1'b1 || note !== 3'd5)
      $display("FAIL la_relock got valid=%b note=%0d want 1 5", note_valid, note); else n_pass++;
  endtask

  task automatic test_boundary();
    drive_half(3035 + TOLB + 1, 1'b1);
    drive_half(3035 + TOLB + 1, 1'b1);
    n_total++; if (note_valid !== 1'b1 || note !== 3'd2)
      $display("FAIL tol_edge got valid=%b note=%0d want 1 2", note_valid, note); else n_pass++;
    n_total++; if (int'(half_period) != 3035 + TOLB)
      $display("FAIL tol_hp got %0d want %0d", half_period, 3035 + TOLB); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      drive_half(3035 + TOLB + 2, 1'b1);
      n_total++; if (note_valid !== 1'b0 || silence !== 1'b0)
        $display("FAIL tol_over%0d got valid=%b silence=%b want 0 0", k, note_valid, silence); else n_pass++;
    end
  endtask

  task automatic test_silence();
    int t0, waited;
    t0 = last_tgl;
    waited = 0;
    while (silence !== 1'b1 && waited < SAT + 200) begin
      @(negedge clk);
      waited++;
    end
    n_total++; if (silence !== 1'b1 || cyc - t0 < SAT || cyc - t0 > SAT + 12)
      $display("FAIL silence_time got silence=%b after %0d clk want 1 after %0d..%0d", silence, cyc - t0, SAT, SAT + 12);
    else n_pass++;
    n_total++; if (note_valid !== 1'b0 || int'(note) != m_note)
      $display("FAIL silence_hold got valid=%b note=%0d want 0 %0d", note_valid, note, m_note); else n_pass++;
    m_silent = 1; m_run = 0; m_valid = 0;
  endtask

  task automatic test_glitch();
    int s0;
    drive_half(100, 1'b1);
    drive_half(2025, 1'b1);
    drive_half(2025, 1'b1);
    n_total++; if (note_valid !== 1'b1 || note !== 3'd6)
      $display("FAIL xi_lock got valid=%b note=%0d want 1 6", note_valid, note); else n_pass++;
    drive_half(1000, 1'b0);
    drive_half(5, 1'b1);
    n_total++; if (note_valid !== 1'b0) $display("FAIL glitch_drop got valid=%b want 0", note_valid); else n_pass++;
    s0 = strobes;
    drive_half(2025, 1'b1);
    n_total++; if (note_valid !== 1'b0) $display("FAIL glitch_one got valid=%b want 0", note_valid); else n_pass++;
    drive_half(2025, 1'b1);
    n_total++; if (note_valid !== 1'b1 || note !== 3'd6 || strobes - s0 != 1)
      $display("FAIL glitch_relock got valid=%b note=%0d strobes=%0d want 1 6 1", note_valid, note, strobes - s0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 3; seg++) begin
      int k, j;
      k = int'($urandom_range(7, 0));
      for (int r = 0; r < 2; r++) begin
        j = int'($urandom_range(40, 0)) - 20;
        drive_half(exp_ticks[k] + 1 + j, 1'b1);
        n_total++;
        if (int'(note_valid) != m_valid || int'(note) != m_note || int'(silence) != m_silent ||
            int'(half_period) != m_hp || strobes != m_strobes)
          $display("FAIL rand_s%0d_r%0d got valid=%b note=%0d sil=%b hp=%0d strb=%0d want %0d %0d %0d %0d %0d",
                   seg, r, note_valid, note, silence, half_period, strobes,
                   m_valid, m_note, m_silent, m_hp, m_strobes);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_total++; if (note !== 3'd0 || note_valid !== 1'b0 || note_strobe !== 1'b0 ||
                   silence !== 1'b1 || half_period !== 13'd0)
      $display("FAIL mid_reset got note=%0d valid=%b strb=%b sil=%b hp=%0d want 0 0 0 1 0",
               note, note_valid, note_strobe, silence, half_period);
    else n_pass++;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (CHK) @(negedge clk);
    n_total++; if (silence !== 1'b1 || note_valid !== 1'b0)
      $display("FAIL mid_release got silence=%b valid=%b want 1 0", silence, note_valid); else n_pass++;
  endtask

  initial begin
    m_strobes = 0;
    model_reset();
    test_reset();
    test_duo();
    test_switch();
    test_boundary();
    test_silence();
    test_glitch();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout after %0d clk", cyc);
    $fatal(1, "timeout");
  end

endmodule
